// File: rtl/rv_thread_sched.sv
// Hardware thread scheduler for the multithreaded rv_cpu_top core.
// Holds per-thread PC and run state and issues one READY thread per cycle,
// round-robin, into the shared pipeline. Writeback reports each thread's
// next PC and disposition. External wake pulses release waiting threads.
module rv_thread_sched #(
  parameter int              NTHREADS = 4,
  parameter int              TID_W    = 2,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spawn_valid,
  input  logic [TID_W-1:0]    spawn_tid,
  input  logic [PC_W-1:0]     spawn_pc,
  output logic                spawn_ready,
  input  logic                stall,
  output logic                issue_valid,
  output logic [TID_W-1:0]    issue_tid,
  output logic [PC_W-1:0]     issue_pc,
  input  logic                upd_valid,
  input  logic [TID_W-1:0]    upd_tid,
  input  logic [PC_W-1:0]     upd_pc,
  input  logic [1:0]          upd_op,
  input  logic [NTHREADS-1:0] wake,
  output logic [NTHREADS-1:0] thread_active,
  output logic                all_halted
);

  typedef enum logic [1:0] {
    T_OFF      = 2'd0,
    T_READY    = 2'd1,
    T_INFLIGHT = 2'd2,
    T_WAIT     = 2'd3
  } tstate_t;

  localparam logic [1:0] OP_CONT = 2'b00;
  localparam logic [1:0] OP_WAIT = 2'b01;

  tstate_t          state_q [NTHREADS];
  tstate_t          state_d [NTHREADS];
  logic [PC_W-1:0]  pc_q    [NTHREADS];
  logic [PC_W-1:0]  pc_d    [NTHREADS];
  logic [TID_W-1:0] rr_ptr;

  logic             found;
  logic [TID_W-1:0] win_tid;
  logic [TID_W-1:0] cand;
  logic             issue_go;

  // Round-robin pick: first READY thread starting just after rr_ptr.
  // NOTE: every variable driven here gets a default before any condition,
  // otherwise paths that skip an assignment would infer a latch.
  always_comb begin
    found   = 1'b0;
    win_tid = '0;
    cand    = '0;
    for (int k = 1; k <= NTHREADS; k++) begin
      // Truncation to TID_W bits is the modulo-NTHREADS wrap.
      cand = rr_ptr + TID_W'(k);
      if (!found && state_q[cand] == T_READY) begin
        found   = 1'b1;
        win_tid = cand;
      end
    end
  end

  assign issue_go = found && !stall;

  // Per-thread next state: the four triggers (spawn, issue, update, wake)
  // each act on a distinct current state, so they never collide on a thread.
  always_comb begin
    for (int i = 0; i < NTHREADS; i++) begin
      state_d[i] = state_q[i];
      pc_d[i]    = pc_q[i];
      unique case (state_q[i])
        T_OFF: begin
          if (spawn_valid && spawn_tid == TID_W'(i)) begin
            state_d[i] = T_READY;
            pc_d[i]    = spawn_pc;
          end
        end
        T_READY: begin
          if (issue_go && win_tid == TID_W'(i)) state_d[i] = T_INFLIGHT;
        end
        T_INFLIGHT: begin
          if (upd_valid && upd_tid == TID_W'(i)) begin
            pc_d[i] = upd_pc;
            if (upd_op == OP_CONT)      state_d[i] = T_READY;
            else if (upd_op == OP_WAIT) state_d[i] = wake[i] ? T_READY : T_WAIT;
            else                        state_d[i] = T_OFF;   // halt and reserved
          end
        end
        T_WAIT: begin
          if (wake[i]) state_d[i] = T_READY;
        end
        default: state_d[i] = state_q[i];
      endcase
    end
  end

  // Thread state and PC registers.
  // NOTE: the PC file is small and its post-reset contents are visible
  // (thread 0 starts at RESET_PC), so it is reset like ordinary flops.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTHREADS; i++) begin
        state_q[i] <= (i == 0) ? T_READY : T_OFF;
        pc_q[i]    <= (i == 0) ? RESET_PC : '0;
      end
    end else begin
      for (int i = 0; i < NTHREADS; i++) begin
        state_q[i] <= state_d[i];
        pc_q[i]    <= pc_d[i];
      end
    end
  end

  // Issue registers and round-robin pointer; everything holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_tid   <= '0;
      issue_pc    <= '0;
      rr_ptr      <= TID_W'(NTHREADS - 1);
    end else if (!stall) begin
      if (found) begin
        issue_valid <= 1'b1;
        issue_tid   <= win_tid;
        issue_pc    <= pc_q[win_tid];
        rr_ptr      <= win_tid;
      end else begin
        issue_valid <= 1'b0;
      end
    end
  end

  // Status outputs decoded straight from the state registers.
  always_comb begin
    for (int i = 0; i < NTHREADS; i++) begin
      thread_active[i] = (state_q[i] != T_OFF);
    end
  end

  assign all_halted  = ~|thread_active;
  assign spawn_ready = (state_q[spawn_tid] == T_OFF);

endmodule

// File: tb/tb_rv_thread_sched.sv
// Directed bench for rv_thread_sched. A small pipeline responder answers
// every accepted issue with a writeback two cycles after the issue loads;
// per-thread scoreboard queues hold the PCs each thread must issue next.
module tb_rv_thread_sched;

  localparam int NT = 4;
  localparam int TW = 2;
  localparam int PW = 32;
  localparam logic [1:0] OP_CONT = 2'b00;
  localparam logic [1:0] OP_WAIT = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          spawn_valid = 1'b0;
  logic [TW-1:0] spawn_tid = '0;
  logic [PW-1:0] spawn_pc = '0;
  logic          spawn_ready;
  logic          stall = 1'b0;
  logic          issue_valid;
  logic [TW-1:0] issue_tid;
  logic [PW-1:0] issue_pc;
  logic          upd_valid = 1'b0;
  logic [TW-1:0] upd_tid = '0;
  logic [PW-1:0] upd_pc = '0;
  logic [1:0]    upd_op = '0;
  logic [NT-1:0] wake = '0;
  logic [NT-1:0] thread_active;
  logic          all_halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] exp_q [NT][$];
  logic [1:0]    plan_op   [NT];
  logic          plan_wake [NT];
  int            hist_tid[$];

  rv_thread_sched #(
    .NTHREADS(NT), .TID_W(TW), .PC_W(PW), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .spawn_valid(spawn_valid), .spawn_tid(spawn_tid), .spawn_pc(spawn_pc),
    .spawn_ready(spawn_ready),
    .stall(stall),
    .issue_valid(issue_valid), .issue_tid(issue_tid), .issue_pc(issue_pc),
    .upd_valid(upd_valid), .upd_tid(upd_tid), .upd_pc(upd_pc), .upd_op(upd_op),
    .wake(wake),
    .thread_active(thread_active), .all_halted(all_halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int hist_at(input int i);
    return (i < hist_tid.size()) ? hist_tid[i] : -1;
  endfunction

  function automatic int hist_count(input int tid);
    int n = 0;
    foreach (hist_tid[k]) if (hist_tid[k] == tid) n++;
    return n;
  endfunction

  // One clock: detect the issue accepted at this edge, score it, and drive
  // the writeback for it during the following cycle.
  task automatic step();
    logic          pv;
    logic          pst;
    logic [TW-1:0] ptid;
    logic [PW-1:0] ppc;
    pv   = issue_valid;
    pst  = stall;
    ptid = issue_tid;
    ppc  = issue_pc;
    @(posedge clk);
    #1;
    spawn_valid = 1'b0;
    wake        = '0;
    upd_valid   = 1'b0;
    if (pv && !pst) begin
      hist_tid.push_back(int'(ptid));
      check($sformatf("sb_expected_t%0d", ptid), 64'(exp_q[ptid].size() > 0), 64'd1);
      if (exp_q[ptid].size() > 0)
        check($sformatf("issue_pc_t%0d", ptid), 64'(ppc), 64'(exp_q[ptid].pop_front()));
      upd_valid = 1'b1;
      upd_tid   = ptid;
      upd_pc    = ppc + 32'd4;
      upd_op    = plan_op[ptid];
      if (plan_wake[ptid]) wake[ptid] = 1'b1;
      if (plan_op[ptid] != OP_HALT) exp_q[ptid].push_back(ppc + 32'd4);
      plan_op[ptid]   = OP_CONT;
      plan_wake[ptid] = 1'b0;
    end
  endtask

  task automatic wait_accept(input int tid, input int max_steps, output bit seen, output int used);
    seen = 1'b0;
    used = 0;
    hist_tid.delete();
    while (!seen && used < max_steps) begin
      step();
      used++;
      if (hist_count(tid) > 0) seen = 1'b1;
    end
  endtask

  task automatic do_spawn(input int tid, input logic [PW-1:0] pc, input bit expect_ok);
    spawn_tid   = TW'(tid);
    spawn_pc    = pc;
    spawn_valid = 1'b1;
    #1;
    check($sformatf("spawn_ready_t%0d", tid), 64'(spawn_ready), 64'(expect_ok));
    if (expect_ok) exp_q[tid].push_back(pc);
  endtask

  initial begin
    int  nvalid;
    bit  seen;
    int  used;

    for (int i = 0; i < NT; i++) begin
      plan_op[i]   = OP_CONT;
      plan_wake[i] = 1'b0;
    end

    // ---- 1: reset state, single thread running with bubbles ----
    #1 rst = 1'b1;
    #3;
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_issue_tid", 64'(issue_tid), 64'd0);
    check("rst_issue_pc", 64'(issue_pc), 64'd0);
    check("rst_thread_active", 64'(thread_active), 64'b0001);
    check("rst_all_halted", 64'(all_halted), 64'd0);
    spawn_tid = 2'd1;
    #1;
    check("rst_spawn_ready_t1", 64'(spawn_ready), 64'd1);
    spawn_tid = 2'd0;
    #1;
    check("rst_spawn_ready_t0", 64'(spawn_ready), 64'd0);
    exp_q[0].push_back(32'h0);
    #5 rst = 1'b0;

    nvalid = 0;
    hist_tid.delete();
    for (int c = 0; c < 9; c++) begin
      step();
      if (issue_valid) nvalid++;
      if (c == 1) check("t1_bubble_after_issue", 64'(issue_valid), 64'd0);
    end
    check("t1_issue_count", 64'(nvalid), 64'd3);
    check("t1_accept_count_t0", 64'(hist_count(0)), 64'd3);

    // ---- 2: spawn t1, t2; round-robin order ----
    hist_tid.delete();
    do_spawn(1, 32'h100, 1'b1);
    step();
    spawn_tid = 2'd1;
    #1;
    check("spawn_ready_drop_t1", 64'(spawn_ready), 64'd0);
    do_spawn(2, 32'h200, 1'b1);
    step();
    spawn_tid = 2'd2;
    #1;
    check("spawn_ready_drop_t2", 64'(spawn_ready), 64'd0);
    nvalid = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (issue_valid) nvalid++;
    end
    check("t2_no_bubbles", 64'(nvalid), 64'd3);
    check("t2_order0", 64'(hist_at(0)), 64'd0);
    check("t2_order1", 64'(hist_at(1)), 64'd1);
    check("t2_order2", 64'(hist_at(2)), 64'd2);
    check("t2_order3", 64'(hist_at(3)), 64'd0);
    check("t2_present_t1", 64'({issue_valid, issue_tid, issue_pc}), {1'b1, 2'd1, 32'h104});

    // ---- 3: stall holds the presented issue ----
    plan_op[1] = OP_WAIT;
    stall = 1'b1;
    hist_tid.delete();
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("t3_stall_hold_%0d", c), 64'({issue_valid, issue_tid, issue_pc}),
            {1'b1, 2'd1, 32'h104});
    end
    check("t3_no_accept_in_stall", 64'(hist_tid.size()), 64'd0);
    check("t3_active_in_stall", 64'(thread_active), 64'b0111);
    stall = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("t3_resume0", 64'(hist_at(0)), 64'd1);
    check("t3_resume1", 64'(hist_at(1)), 64'd2);
    check("t3_resume2", 64'(hist_at(2)), 64'd0);

    // ---- 4: wait, late wake, then coincident wake ----
    hist_tid.delete();
    for (int c = 0; c < 5; c++) step();
    check("t4_t1_parked", 64'(hist_count(1)), 64'd0);
    check("t4_t1_still_active", 64'(thread_active[1]), 64'd1);
    plan_op[1]   = OP_WAIT;
    plan_wake[1] = 1'b1;
    wake[1] = 1'b1;
    wait_accept(1, 10, seen, used);
    check("t4_t1_after_wake", 64'(seen), 64'd1);
    wait_accept(1, 6, seen, used);
    check("t4_t1_coincident_wake", 64'(seen), 64'd1);

    // ---- 5: halt all, spawn t3, ignored respawn ----
    for (int i = 0; i < 3; i++) plan_op[i] = OP_HALT;
    used = 0;
    while (!all_halted && used < 20) begin
      step();
      used++;
    end
    check("t5_all_halted", 64'(all_halted), 64'd1);
    check("t5_thread_active", 64'(thread_active), 64'b0000);
    check("t5_issue_idle", 64'(issue_valid), 64'd0);
    for (int i = 0; i < 3; i++)
      check($sformatf("t5_sb_drained_t%0d", i), 64'(exp_q[i].size()), 64'd0);
    do_spawn(3, 32'h300, 1'b1);
    step();
    step();
    check("t5_t3_issue", 64'({issue_valid, issue_tid, issue_pc}), {1'b1, 2'd3, 32'h300});
    do_spawn(3, 32'h3F0, 1'b0);
    for (int c = 0; c < 5; c++) step();
    check("t5_t3_reissued", 64'(hist_count(3)), 64'd2);

    // ---- 6: asynchronous reset mid-run ----
    do_spawn(2, 32'h500, 1'b1);
    plan_op[3] = OP_WAIT;
    for (int c = 0; c < 6; c++) step();
    used = 0;
    while (!issue_valid && used < 10) begin
      step();
      used++;
    end
    check("t6_busy_before_rst", 64'(issue_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_issue", 64'({issue_valid, issue_tid, issue_pc}), 64'd0);
    check("t6_rst_active", 64'(thread_active), 64'b0001);
    spawn_valid = 1'b0;
    upd_valid   = 1'b0;
    wake        = '0;
    for (int i = 0; i < NT; i++) begin
      exp_q[i].delete();
      plan_op[i]   = OP_CONT;
      plan_wake[i] = 1'b0;
    end
    exp_q[0].push_back(32'h0);
    #12 rst = 1'b0;
    hist_tid.delete();
    for (int c = 0; c < 9; c++) step();
    check("t6_only_t0_count", 64'(hist_count(0)), 64'd3);
    check("t6_only_t0_total", 64'(hist_tid.size()), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
